// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side handshake and operands, forwarding taps, and the EX-side entry.
// The master modport is the driving environment; the slave modport is the stage itself.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] rs_data_i;
    logic [DW-1:0] rt_data_i;
    logic [DW-1:0] imm_i;
    logic [AW-1:0] rs_addr_i;
    logic [AW-1:0] rt_addr_i;
    logic [AW-1:0] rd_addr_i;
    logic          alusrc_i;
    logic          regdst_i;
    logic          regwrite_i;
    logic [2:0]    aluop_i;
    logic [5:0]    funct_i;
    logic          flush_i;
    logic          exm_regwrite_i;
    logic [AW-1:0] exm_wr_addr_i;
    logic [DW-1:0] exm_result_i;
    logic          mwb_regwrite_i;
    logic [AW-1:0] mwb_wr_addr_i;
    logic [DW-1:0] mwb_result_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] src1_o;
    logic [DW-1:0] src2_o;
    logic [3:0]    ctrl_o;
    logic [AW-1:0] wr_addr_o;
    logic          regwrite_o;
    logic          err_o;

    modport master (
        output in_valid_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
               alusrc_i, regdst_i, regwrite_i, aluop_i, funct_i, flush_i,
               exm_regwrite_i, exm_wr_addr_i, exm_result_i,
               mwb_regwrite_i, mwb_wr_addr_i, mwb_result_i, out_ready_i,
        input  in_ready_o, out_valid_o, src1_o, src2_o, ctrl_o, wr_addr_o, regwrite_o, err_o
    );

    modport slave (
        input  in_valid_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i,
               alusrc_i, regdst_i, regwrite_i, aluop_i, funct_i, flush_i,
               exm_regwrite_i, exm_wr_addr_i, exm_result_i,
               mwb_regwrite_i, mwb_wr_addr_i, mwb_result_i, out_ready_i,
        output in_ready_o, out_valid_o, src1_o, src2_o, ctrl_o, wr_addr_o, regwrite_o, err_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// Single-entry ID/EX stage: operand forwarding at capture, ALU control decode, valid/ready.
// Optional ID_EX_ILLEGAL_TRAP_EN: drop illegal ops and raise a sticky err_o instead of issuing them.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input logic          clk_i,
    input logic          rst_i,
    id_ex_stage_if.slave bus
);
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          vld_p0;
    logic [DW-1:0] src1_p0, src2_p0;
    logic [3:0]    ctrl_p0;
    logic [AW-1:0] wr_addr_p0;
    logic          regwrite_p0;

    logic [4:0]    dec;
    logic          legal;
    logic          in_ready;
    logic          accept;
    logic          capture;
    logic [DW-1:0] fwd_rs, fwd_rt;

    // Returns {legal, ctrl}; illegal combinations decode to ADD so the non-trap build issues a harmless op.
    function automatic logic [4:0] decode_ctrl(input logic [2:0] aluop, input logic [5:0] funct);
        case (aluop)
            3'b000:  return {1'b1, CTRL_ADD};
            3'b001:  return {1'b1, CTRL_SUB};
            3'b011:  return {1'b1, CTRL_AND};
            3'b100:  return {1'b1, CTRL_OR};
            3'b101:  return {1'b1, CTRL_SLT};
            3'b010: begin
                case (funct)
                    6'b100000: return {1'b1, CTRL_ADD};
                    6'b100010: return {1'b1, CTRL_SUB};
                    6'b100100: return {1'b1, CTRL_AND};
                    6'b100101: return {1'b1, CTRL_OR};
                    6'b101010: return {1'b1, CTRL_SLT};
                    6'b100111: return {1'b1, CTRL_NOR};
                    default:   return {1'b0, CTRL_ADD};
                endcase
            end
            default: return {1'b0, CTRL_ADD};
        endcase
    endfunction

    // EX/MEM is the younger producer, so it wins over MEM/WB; register 0 is hardwired and never forwarded.
    function automatic logic [DW-1:0] fwd_operand(
        input logic [AW-1:0] addr,
        input logic [DW-1:0] rf_data,
        input logic          exm_we,
        input logic [AW-1:0] exm_wa,
        input logic [DW-1:0] exm_res,
        input logic          mwb_we,
        input logic [AW-1:0] mwb_wa,
        input logic [DW-1:0] mwb_res
    );
        if (addr == '0)                     return rf_data;
        else if (exm_we && exm_wa == addr)  return exm_res;
        else if (mwb_we && mwb_wa == addr)  return mwb_res;
        else                                return rf_data;
    endfunction

    always_comb begin
        dec      = decode_ctrl(bus.aluop_i, bus.funct_i);
        legal    = dec[4];
        in_ready = bus.flush_i | ~vld_p0 | bus.out_ready_i;
        accept   = bus.in_valid_i & in_ready & ~bus.flush_i;
`ifdef ID_EX_ILLEGAL_TRAP_EN
        capture  = accept & legal;
`else
        capture  = accept;
`endif
        fwd_rs   = fwd_operand(bus.rs_addr_i, bus.rs_data_i,
                               bus.exm_regwrite_i, bus.exm_wr_addr_i, bus.exm_result_i,
                               bus.mwb_regwrite_i, bus.mwb_wr_addr_i, bus.mwb_result_i);
        fwd_rt   = fwd_operand(bus.rt_addr_i, bus.rt_data_i,
                               bus.exm_regwrite_i, bus.exm_wr_addr_i, bus.exm_result_i,
                               bus.mwb_regwrite_i, bus.mwb_wr_addr_i, bus.mwb_result_i);
    end

    // Occupancy FSM: flush beats capture, capture beats consume.
    always_comb begin
        state_d = state_q;
        if (bus.flush_i)
            state_d = EMPTY;
        else if (capture)
            state_d = FULL;
        else if (state_q == FULL && bus.out_ready_i)
            state_d = EMPTY;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    assign vld_p0 = (state_q == FULL);

    // ---- capture boundary: ID -> EX entry register ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src1_p0     <= '0;
            src2_p0     <= '0;
            ctrl_p0     <= 4'b0000;
            wr_addr_p0  <= '0;
            regwrite_p0 <= 1'b0;
        end else if (capture) begin
            src1_p0     <= fwd_rs;
            src2_p0     <= bus.alusrc_i ? bus.imm_i : fwd_rt;
            ctrl_p0     <= dec[3:0];
            wr_addr_p0  <= bus.regdst_i ? bus.rd_addr_i : bus.rt_addr_i;
            regwrite_p0 <= bus.regwrite_i & legal;
        end
    end

`ifdef ID_EX_ILLEGAL_TRAP_EN
    logic err_p0;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_p0 <= 1'b0;
        else if (accept && !legal)
            err_p0 <= 1'b1;
    end

    assign bus.err_o = err_p0;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = vld_p0;
    assign bus.src1_o      = src1_p0;
    assign bus.src2_o      = src2_p0;
    assign bus.ctrl_o      = ctrl_p0;
    assign bus.wr_addr_o   = wr_addr_p0;
    assign bus.regwrite_o  = regwrite_p0;
endmodule
